// File: rtl/connect_board_renderer.sv
// Connect-4 pixel renderer: 2-stage pixel pipeline with circular chips and a frame-stepped drop animation.
// Optional macro HOVER_BLINK_EN: the hover chip blinks 16 frames on / 16 frames off.
module connect_board_renderer #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int PITCH   = 65,
    parameter int RADIUS  = 27,
    parameter int X0      = 125,
    parameter int Y0      = 442,
    parameter int MARGIN  = 37,
    parameter int HOVER_Y = 40,
    parameter int STEP    = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [9:0]                pix_x,
    input  logic [9:0]                pix_y,
    input  logic                      in_display,
    input  logic                      frame_start,
    input  logic [ROWS*COLS-1:0]      board,
    input  logic [ROWS*COLS-1:0]      colors,
    input  logic [$clog2(COLS)-1:0]   selected_col,
    input  logic                      player,
    input  logic                      drop_req,
    input  logic [$clog2(COLS)-1:0]   drop_col,
    input  logic [$clog2(ROWS)-1:0]   drop_row,
    input  logic                      drop_color,
    output logic                      drop_busy,
    output logic                      drop_done,
    output logic [2:0]                vga_r,
    output logic [2:0]                vga_g,
    output logic [1:0]                vga_b
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    typedef logic signed [10:0] coord_t;

    localparam coord_t      RAD   = coord_t'(RADIUS);
    localparam logic [21:0] R2    = 22'(RADIUS * RADIUS);
    localparam coord_t      BX_LO = coord_t'(X0 - MARGIN);
    localparam coord_t      BX_HI = coord_t'(X0 + (COLS - 1) * PITCH + MARGIN);
    localparam coord_t      BY_LO = coord_t'(Y0 - (ROWS - 1) * PITCH - MARGIN);
    localparam coord_t      BY_HI = coord_t'(Y0 + MARGIN);
    localparam coord_t      HY    = coord_t'(HOVER_Y);

    localparam logic [7:0] WHITE  = 8'b111_111_11;
    localparam logic [7:0] YELLOW = 8'b110_110_00;
    localparam logic [7:0] RED    = 8'b110_000_00;
    localparam logic [7:0] BLACK  = 8'b000_000_00;

    typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;

    function automatic coord_t col_x(input int c);
        return coord_t'(X0 + c * PITCH);
    endfunction

    function automatic coord_t row_y(input int r);
        return coord_t'(Y0 - r * PITCH);
    endfunction

    function automatic logic in_rad(input coord_t d);
        return (d >= -RAD) && (d <= RAD);
    endfunction

    function automatic logic [21:0] sq(input coord_t d);
        logic [10:0] a;
        logic [21:0] w;
        a = d[10] ? 11'(-d) : 11'(d);
        w = {11'b0, a};
        return w * w;
    endfunction

    function automatic logic in_disc(input coord_t dx, input coord_t dy);
        return (sq(dx) + sq(dy)) <= R2;
    endfunction

    // ---------------- drop animation FSM ----------------
    state_t        state_q;
    logic [9:0]    drop_y_q;
    logic [CW-1:0] dcol_q;
    logic [RW-1:0] drow_q;
    logic          dclr_q;
    logic          done_q;

    logic [9:0]  tgt_y;
    logic [10:0] step_y;
    logic        reached;
    logic        req_ok;

    always_comb begin
        tgt_y   = 10'(Y0 - int'(drow_q) * PITCH);
        step_y  = {1'b0, drop_y_q} + 11'(STEP);
        reached = step_y >= {1'b0, tgt_y};
        req_ok  = drop_req && (int'(drop_col) < COLS) && (int'(drop_row) < ROWS);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            drop_y_q <= 10'(HOVER_Y);
            dcol_q   <= '0;
            drow_q   <= '0;
            dclr_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (req_ok) begin
                    state_q  <= FALL;
                    dcol_q   <= drop_col;
                    drow_q   <= drop_row;
                    dclr_q   <= drop_color;
                    drop_y_q <= 10'(HOVER_Y);
                end
                FALL: if (frame_start) begin
                    if (reached) begin
                        drop_y_q <= tgt_y;
                        state_q  <= LAND;
                    end else begin
                        drop_y_q <= step_y[9:0];
                    end
                end
                LAND: if (frame_start) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drop_busy = (state_q != IDLE);
    assign drop_done = done_q;

    logic hover_en;
`ifdef HOVER_BLINK_EN
    logic [4:0] blink_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)            blink_q <= '0;
        else if (frame_start) blink_q <= blink_q + 5'd1;
    end
    assign hover_en = ~blink_q[4];
`else
    assign hover_en = 1'b1;
`endif

    // ---------------- stage 1: cell match and deltas ----------------
    coord_t        xs, ys;
    logic          col_hit, row_hit;
    logic [CW-1:0] col_i;
    logic [RW-1:0] row_i;
    coord_t        dx_d, dy_d, ddx_d, ddy_d, hdx_d, hdy_d;
    logic          rect_d, cell_d, occ_d, clr_d, mask_d;

    assign xs = coord_t'({1'b0, pix_x});
    assign ys = coord_t'({1'b0, pix_y});

    // Cells are further apart than a chip diameter, so at most one column and one row can match.
    always_comb begin
        coord_t d;
        col_hit = 1'b0;
        col_i   = '0;
        dx_d    = '0;
        row_hit = 1'b0;
        row_i   = '0;
        dy_d    = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            d = xs - col_x(int'(c));
            if (in_rad(d)) begin
                col_hit = 1'b1;
                col_i   = CW'(c);
                dx_d    = d;
            end
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            d = ys - row_y(int'(r));
            if (in_rad(d)) begin
                row_hit = 1'b1;
                row_i   = RW'(r);
                dy_d    = d;
            end
        end
        cell_d = col_hit && row_hit;
        occ_d  = 1'b0;
        clr_d  = 1'b0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (cell_d && row_i == RW'(r) && col_i == CW'(c)) begin
                    occ_d = board[r * COLS + c];
                    clr_d = colors[r * COLS + c];
                end
            end
        end
        mask_d = drop_busy && (row_i == drow_q) && (col_i == dcol_q);
        ddx_d  = xs - col_x(int'(dcol_q));
        ddy_d  = ys - coord_t'({1'b0, drop_y_q});
        hdx_d  = xs - col_x(int'(selected_col));
        hdy_d  = ys - HY;
        rect_d = (xs >= BX_LO) && (xs <= BX_HI) && (ys >= BY_LO) && (ys <= BY_HI);
    end

    logic   v1_q, rect_q, cell_q, occ_q, clr_q, mask_q;
    logic   fall_q, dclr1_q, hover_q, player_q;
    coord_t dx_q, dy_q, ddx_q, ddy_q, hdx_q, hdy_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1_q     <= 1'b0;
            rect_q   <= 1'b0;
            cell_q   <= 1'b0;
            occ_q    <= 1'b0;
            clr_q    <= 1'b0;
            mask_q   <= 1'b0;
            fall_q   <= 1'b0;
            dclr1_q  <= 1'b0;
            hover_q  <= 1'b0;
            player_q <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            ddx_q    <= '0;
            ddy_q    <= '0;
            hdx_q    <= '0;
            hdy_q    <= '0;
        end else begin
            v1_q     <= in_display;
            rect_q   <= rect_d;
            cell_q   <= cell_d;
            occ_q    <= occ_d;
            clr_q    <= clr_d;
            mask_q   <= mask_d;
            fall_q   <= drop_busy;
            dclr1_q  <= dclr_q;
            hover_q  <= !drop_busy && hover_en;
            player_q <= player;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            ddx_q    <= ddx_d;
            ddy_q    <= ddy_d;
            hdx_q    <= hdx_d;
            hdy_q    <= hdy_d;
        end
    end

    // ---------------- stage 2: squares, priority, colour pins ----------------
    logic [7:0] rgb_d, rgb_q;

    always_comb begin
        rgb_d = WHITE;
        if (rect_q) rgb_d = YELLOW;
        if (cell_q && in_disc(dx_q, dy_q))
            rgb_d = (occ_q && !mask_q) ? (clr_q ? BLACK : RED) : WHITE;
        if (fall_q && in_disc(ddx_q, ddy_q))
            rgb_d = dclr1_q ? BLACK : RED;
        if (hover_q && in_disc(hdx_q, hdy_q))
            rgb_d = player_q ? BLACK : RED;
        if (!v1_q) rgb_d = '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) rgb_q <= '0;
        else       rgb_q <= rgb_d;
    end

    assign vga_r = rgb_q[7:5];
    assign vga_g = rgb_q[4:2];
    assign vga_b = rgb_q[1:0];

endmodule

// File: doc/connect_board_renderer.md
# connect_board_renderer

Parametrised Connect-4 pixel renderer with a falling-chip drop animation. It sits between the sync generator (pixel counters, display enable, frame-start pulse) and the game FSM (board occupancy, colours, cursor, drop requests), and drives the 8-bit 3-3-2 VGA colour pins. Compared with the fixed 7x6 display it adds board geometry parameters, true circular chips, a registered 2-stage pixel pipeline, and a frame-stepped drop animation with a busy/done handshake.

## Interface
- ROWS, 6, board rows; row 0 is the bottom row.
- COLS, 7, board columns; column 0 is the leftmost.
- PITCH, 65, pixel distance between adjacent cell centres.
- RADIUS, 27, chip radius in pixels.
- X0, 125, x of the column-0 centre.
- Y0, 442, y of the row-0 centre; row r centre is at Y0 - r*PITCH.
- MARGIN, 37, distance from the outer cell centres to the yellow board edge.
- HOVER_Y, 40, y centre of the hover chip and the start height of a drop.
- STEP, 8, pixels the falling chip moves per frame.
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high.
- pix_x, pix_y  in  10 each  current pixel coordinates.
- in_display  in  1  visible-area enable.
- frame_start  in  1  one-cycle pulse per frame.
- board  in  ROWS*COLS  occupancy; bit index is row*COLS+col.
- colors  in  ROWS*COLS  chip colour; 1 = black, 0 = red.
- selected_col  in  $clog2(COLS)  cursor column.
- player  in  1  1 = black to move, 0 = red to move.
- drop_req  in  1  one-cycle request to start a drop.
- drop_col  in  $clog2(COLS)  column of the drop.
- drop_row  in  $clog2(ROWS)  landing row of the drop.
- drop_color  in  1  colour of the falling chip.
- drop_busy  out  1  high while a drop animation is in progress.
- drop_done  out  1  one-cycle pulse when the drop animation ends.
- vga_r  out  3  red colour pins.
- vga_g  out  3  green colour pins.
- vga_b  out  2  blue colour pins.

## Operation
**Colour priority, lowest first**
1. White background.
2. Yellow board rectangle, inclusive bounds:
   - x from X0-MARGIN to X0+(COLS-1)*PITCH+MARGIN;
   - y from Y0-(ROWS-1)*PITCH-MARGIN to Y0+MARGIN.
3. Cell disc: dx²+dy² <= RADIUS², where dx and dy are measured from the cell centre. The disc is black or red if the board bit is set, white otherwise.
4. Masked cell: while state is FALL or LAND, the cell (drop_row, drop_col) is drawn white regardless of its board bit.
5. Falling chip: in FALL or LAND, a disc of drop_color centred at (column centre of drop_col, drop_y), drawn over everything.
6. Hover chip: in IDLE only, a disc of the player colour centred at (column centre of selected_col, HOVER_Y).

**Colour mapping to {r,g,b}**
- White: 111,111,11.
- Yellow: 110,110,00.
- Red: 110,000,00.
- Black: all zero.
- All outputs are forced to zero when the delayed in_display is low.

**Drop FSM: IDLE, FALL, LAND**
- IDLE to FALL: drop_req with drop_col<COLS and drop_row<ROWS. On this transition latch col, row and colour, and set drop_y=HOVER_Y.
- drop_req while not in IDLE is ignored. An out-of-range drop_req is ignored.
- FALL, on each frame_start:
  - if drop_y+STEP >= target y, set drop_y=target and go to LAND;
  - otherwise drop_y += STEP.
- LAND, on the next frame_start: pulse drop_done for one cycle and go to IDLE.
- drop_busy = (state != IDLE).

**Arithmetic**
- dx and dy are 11-bit signed. Squares and the comparison use 22 bits unsigned.
- drop_y is a 10-bit register.

## Timing
- Pixel pipeline latency is 2 cycles: inputs in cycle n give colour pins in cycle n+2.
- Stage 1 registers:
  - the matched column index and dx (|x - Xc| <= RADIUS);
  - the matched row index and dy;
  - the drop and hover deltas;
  - in_display.
- Stage 2 squares the deltas, resolves priority, and registers the colour pins.
- board, colors, selected_col and player are sampled in stage 1.
- drop_busy rises the cycle after an accepted drop_req.
- drop_done is registered. It is high in the cycle after the frame_start that ends LAND, and drop_busy falls in that same cycle.
- Reset, including mid-animation, forces:
  - state IDLE;
  - drop_y=HOVER_Y;
  - drop_busy=0 and drop_done=0;
  - all colour pins 0;
  - pipeline valid bits 0.

## Configuration
- HOVER_BLINK_EN defined:
  - a 5-bit frame counter increments on frame_start and resets to 0;
  - the hover chip is drawn only when counter bit 4 = 0, i.e. 16 frames on, 16 frames off.
- HOVER_BLINK_EN undefined: no counter exists, and the hover chip is drawn continuously in IDLE.

## Test plan
- **Reset and background:** after Reset, pixel (10,300) with in_display=1 gives {111,111,11} at cycle +2. With in_display=0 the same pixel gives all zero.
- **Disc shape:** board bit 0=1 and colors bit 0=1. Pixel (125,442) gives black. Pixel (125+19,442+19) gives black (722 <= 729). Pixel (125+20,442+20) gives yellow (800 > 729).
- **Drop to row 0:** drop_req with col=0, row=0, colour red.
  - drop_busy=1 on the next cycle.
  - drop_y = 48, 56, … 440 after frame_start 1–50.
  - Frame_start 51 clamps drop_y to 442 and enters LAND.
  - drop_done pulses once after frame_start 52.
  - Cell (125,442) stays white throughout FALL and LAND.
- **Drop to row 5:** drop_row=5 gives a target of 117. drop_y reaches 112 after 9 frames and clamps at frame 10, and drop_done follows frame 11. A second drop_req during the animation is ignored.
- **Invalid and mid-animation reset:** drop_col=7 leaves drop_busy=0. Reset at frame 20 of a fall gives IDLE, drop_busy=0, and the hover chip visible on the next frame.
- **Hover blink (HOVER_BLINK_EN):** with player=1 and selected_col=3, pixel (320,40) is black for frames 0–15 and white for frames 16–31.
